// File: rtl/seq_div_if.sv
// rtl/seq_div_if.sv - start/done handshake and operand/result bus for seq_div
interface seq_div_if;
  logic        start;
  logic [15:0] Pin;
  logic [7:0]  Bin;
  logic [7:0]  Aout;
  logic [7:0]  Rout;
  logic        busy;
  logic        done;
  logic        dz;
  logic        ovf;

  // Requester side: drives the operands and the start request
  modport master (
    output start, Pin, Bin,
    input  Aout, Rout, busy, done, dz, ovf
  );

  // Divider side: consumes operands, returns results and status
  modport slave (
    input  start, Pin, Bin,
    output Aout, Rout, busy, done, dz, ovf
  );
endinterface

// File: rtl/seq_div.sv
// rtl/seq_div.sv - radix-2 restoring 16/8 unsigned divider, one step per clock
module seq_div (
  input  logic      clk,
  input  logic      rst_n,
  seq_div_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [8:0]  rem_q;
  logic [7:0]  quo_q;
  logic [7:0]  div_q;
  logic [2:0]  cnt;

  logic [7:0]  aout_q;
  logic [7:0]  rout_q;
  logic        dz_q;
  logic        ovf_q;

  logic        div_err;
  logic [8:0]  shifted;
  logic [9:0]  diff;
  logic        borrow;
  logic [8:0]  rem_next;
  logic [7:0]  quo_next;

  // A zero divisor, or a high byte not below the divisor, cannot yield an 8-bit quotient
  assign div_err = (bus.Bin == 8'd0) || (bus.Pin[15:8] >= bus.Bin);

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
  assign shifted  = {rem_q[7:0], quo_q[7]};
  assign diff     = {1'b0, shifted} - {2'b00, div_q};
  assign borrow   = diff[9];
  assign rem_next = borrow ? shifted : diff[8:0];
  assign quo_next = {quo_q[6:0], ~borrow};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only matters in IDLE; RUN lasts exactly eight steps
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = div_err ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == 3'd7) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, iterate in RUN, publish results only when entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= 9'd0;
      quo_q  <= 8'd0;
      div_q  <= 8'd0;
      cnt    <= 3'd0;
      aout_q <= 8'd0;
      rout_q <= 8'd0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (div_err) begin
              aout_q <= 8'hFF;
              rout_q <= 8'hFF;
              dz_q   <= (bus.Bin == 8'd0);
              ovf_q  <= (bus.Bin != 8'd0);
            end else begin
              rem_q <= {1'b0, bus.Pin[15:8]};
              quo_q <= bus.Pin[7:0];
              div_q <= bus.Bin;
              cnt   <= 3'd0;
            end
          end
        end
        S_RUN: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            aout_q <= quo_next;
            rout_q <= rem_next[7:0];
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Aout = aout_q;
  assign bus.Rout = rout_q;
  assign bus.dz   = dz_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);

endmodule
